// File: rtl/img_pkg.sv
// Shared definitions for the image frame sequencer: FSM encoding, size defaults,
// processor mode codes and the latched per-frame configuration payload.
package img_pkg;

    localparam int unsigned FRAME_SIZE_DEF = 98304;
    localparam int unsigned ADDR_W_DEF     = 17;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MODE_BRIGHT = 2'b00;
    localparam logic [1:0] MODE_THRESH = 2'b01;
    localparam logic [1:0] MODE_INVERT = 2'b10;
    localparam logic [1:0] MODE_PASS   = 2'b11;

    typedef struct packed {
        logic [7:0] value;
        logic [7:0] threshold;
        logic [1:0] mode;
    } cfg_t;

    // Cycles from a source read to the matching result write.
    function automatic int unsigned total_lat(int unsigned src_lat, int unsigned proc_lat);
        return src_lat + proc_lat + 1;
    endfunction

endpackage

// File: rtl/img_lat_pipe.sv
// Fixed-depth delay line with synchronous flush; carries a valid tag (and any
// payload) alongside data travelling through a fixed-latency datapath.
module img_lat_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/img_frame_sequencer.sv
// Streams one frame from source memory through an external pixel processor into
// result memory, matching processor/memory latency with a valid/address pipe.
module img_frame_sequencer
    import img_pkg::*;
#(
    parameter int unsigned FRAME_SIZE = FRAME_SIZE_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned SRC_LAT    = 1,
    parameter int unsigned PROC_LAT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        cfg_value,
    input  logic [7:0]        cfg_threshold,
    input  logic [1:0]        cfg_mode,
    input  logic              abort,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic [7:0]        proc_ip,
    output logic [7:0]        proc_value,
    output logic [7:0]        proc_threshold,
    output logic [1:0]        proc_s,
    input  logic [7:0]        proc_op,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [7:0]        dst_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pix_cnt
);

    localparam int unsigned       LAT       = total_lat(SRC_LAT, PROC_LAT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_SIZE - 1);

    logic [1:0]        state, state_nxt;
    cfg_t              cfg_q, cfg_nxt;
    logic              busy_nxt, done_nxt, rd_en_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt, pix_nxt;
    logic              flush;
    logic              rd_valid;
    logic [ADDR_W:0]   wr_tag;

    // Abort discards everything still in flight, including pending source returns.
    assign flush = abort && (state == ST_RUN || state == ST_DRAIN);

    always_comb begin
        state_nxt   = state;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        rd_en_nxt   = src_rd_en;
        rd_addr_nxt = src_addr;
        cfg_nxt     = cfg_q;
        pix_nxt     = dst_wr_en ? pix_cnt + ADDR_W'(1) : pix_cnt;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt   = ST_RUN;
                    busy_nxt    = 1'b1;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = '0;
                    pix_nxt     = '0;
                    cfg_nxt     = '{value: cfg_value, threshold: cfg_threshold, mode: cfg_mode};
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    rd_en_nxt = 1'b0;
                end else if (src_addr == LAST_ADDR) begin
                    state_nxt = ST_DRAIN;
                    rd_en_nxt = 1'b0;
                end else begin
                    rd_addr_nxt = src_addr + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else if (dst_wr_en && dst_addr == LAST_ADDR) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                rd_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            src_rd_en <= 1'b0;
            src_addr  <= '0;
            pix_cnt   <= '0;
            cfg_q     <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            src_rd_en <= rd_en_nxt;
            src_addr  <= rd_addr_nxt;
            pix_cnt   <= pix_nxt;
            cfg_q     <= cfg_nxt;
        end
    end

    // Source data lands on the edge that closes its return cycle; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proc_ip <= '0;
        end else if (rd_valid && !flush) begin
            proc_ip <= src_data;
        end
    end

    assign proc_value     = cfg_q.value;
    assign proc_threshold = cfg_q.threshold;
    assign proc_s         = cfg_q.mode;

    img_lat_pipe #(
        .DEPTH (SRC_LAT),
        .WIDTH (1)
    ) u_src_pipe (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .d     (src_rd_en),
        .q     (rd_valid)
    );

    img_lat_pipe #(
        .DEPTH (LAT),
        .WIDTH (ADDR_W + 1)
    ) u_wr_pipe (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .d     ({src_rd_en, src_addr}),
        .q     (wr_tag)
    );

    assign dst_wr_en = wr_tag[ADDR_W];
    assign dst_addr  = wr_tag[ADDR_W-1:0];
    // The processor result is only valid in the write cycle, so it is forwarded
    // straight through and forced to zero whenever no write is issued.
    assign dst_data  = dst_wr_en ? proc_op : 8'd0;

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Runs two sequencers (SRC_LAT/PROC_LAT = 1/0 and 2/2) side by side on a shared
// source memory and checks reads, writes, done and busy against a frame model.
module tb_img_frame_sequencer;

    localparam int unsigned FS = 8;
    localparam int unsigned AW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_value = 8'd0;
    logic [7:0] cfg_threshold = 8'd0;
    logic [1:0] cfg_mode = 2'd0;

    wire [1:0]         src_rd_en, dst_wr_en, busy, done;
    wire [1:0][AW-1:0] src_addr, dst_addr, pix_cnt;
    wire [1:0][7:0]    src_data, proc_ip, proc_value, proc_threshold, proc_op, dst_data;
    wire [1:0][1:0]    proc_s;

    img_frame_sequencer #(.FRAME_SIZE(FS), .ADDR_W(AW), .SRC_LAT(1), .PROC_LAT(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .cfg_value(cfg_value),
        .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode), .abort(abort),
        .src_rd_en(src_rd_en[0]), .src_addr(src_addr[0]), .src_data(src_data[0]),
        .proc_ip(proc_ip[0]), .proc_value(proc_value[0]), .proc_threshold(proc_threshold[0]),
        .proc_s(proc_s[0]), .proc_op(proc_op[0]), .dst_wr_en(dst_wr_en[0]),
        .dst_addr(dst_addr[0]), .dst_data(dst_data[0]), .busy(busy[0]), .done(done[0]),
        .pix_cnt(pix_cnt[0])
    );

    img_frame_sequencer #(.FRAME_SIZE(FS), .ADDR_W(AW), .SRC_LAT(2), .PROC_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .cfg_value(cfg_value),
        .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode), .abort(abort),
        .src_rd_en(src_rd_en[1]), .src_addr(src_addr[1]), .src_data(src_data[1]),
        .proc_ip(proc_ip[1]), .proc_value(proc_value[1]), .proc_threshold(proc_threshold[1]),
        .proc_s(proc_s[1]), .proc_op(proc_op[1]), .dst_wr_en(dst_wr_en[1]),
        .dst_addr(dst_addr[1]), .dst_data(dst_data[1]), .busy(busy[1]), .done(done[1]),
        .pix_cnt(pix_cnt[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Pixel operation of the processor stub, and of the expected-result model.
    function automatic logic [7:0] proc_ref(logic [7:0] ip, logic [7:0] v, logic [7:0] t, logic [1:0] m);
        logic [8:0] sum;
        case (m)
            2'b00: begin
                sum = {1'b0, ip} + {1'b0, v};
                return sum[8] ? 8'hFF : sum[7:0];
            end
            2'b01:   return (ip >= t) ? 8'hFF : 8'h00;
            2'b10:   return ~ip;
            default: return ip;
        endcase
    endfunction

    // Source memories (1- and 2-cycle read latency) and processor stubs (0 and 2 cycles).
    logic [7:0] mem [FS];
    logic [7:0] ra1 = 8'd0, rb1 = 8'd0, rb2 = 8'd0, pb1 = 8'd0, pb2 = 8'd0;
    always @(posedge clk) begin
        if (src_rd_en[0]) ra1 <= mem[src_addr[0][2:0]];
        if (src_rd_en[1]) rb1 <= mem[src_addr[1][2:0]];
        rb2 <= rb1;
        pb1 <= proc_ref(proc_ip[1], proc_value[1], proc_threshold[1], proc_s[1]);
        pb2 <= pb1;
    end
    assign src_data = {rb2, ra1};
    assign proc_op  = {pb2, proc_ref(proc_ip[0], proc_value[0], proc_threshold[0], proc_s[0])};

    typedef struct { int cyc; int addr; int data; } ev_t;
    ev_t rq [2][$];
    ev_t wq [2][$];
    int  dq [2][$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && src_rd_en[d]) rq[d].push_back('{cyc, int'(src_addr[d]), 0});
            if (!rst && dst_wr_en[d]) wq[d].push_back('{cyc, int'(dst_addr[d]), int'(dst_data[d])});
            if (!rst && done[d])      dq[d].push_back(cyc);
        end
    end

    logic [7:0] exp_data [FS];

    function automatic int lat_of(int d);
        return (d == 0) ? 2 : 5;
    endfunction

    function automatic logic [49:0] outs_of(int d);
        return {busy[d], done[d], src_rd_en[d], dst_wr_en[d], src_addr[d], dst_addr[d],
                dst_data[d], proc_ip[d], proc_value[d], proc_threshold[d], proc_s[d], pix_cnt[d]};
    endfunction

    task automatic clear_queues();
        for (int d = 0; d < 2; d++) begin
            rq[d].delete();
            wq[d].delete();
            dq[d].delete();
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < int'(FS); i++) mem[i] = 8'($urandom);
    endtask

    // Runs one frame for 20 cycles; checks busy and the latched configuration every cycle.
    task automatic drive_frame(input int abort_rel, input int restart_rel, input bit scramble, output int t0);
        logic [7:0] v0, th0;
        logic [1:0] m0;
        int last;
        @(posedge clk); #1;
        clear_queues();
        v0 = cfg_value; th0 = cfg_threshold; m0 = cfg_mode;
        for (int i = 0; i < int'(FS); i++) exp_data[i] = proc_ref(mem[i], v0, th0, m0);
        start = 1'b1;
        abort = 1'b0;
        t0 = cyc;
        for (int rel = 1; rel <= 20; rel++) begin
            @(posedge clk); #1;
            start = (rel == restart_rel);
            abort = (rel == abort_rel);
            if (scramble) begin
                cfg_value     = 8'($urandom);
                cfg_threshold = 8'($urandom);
                cfg_mode      = 2'($urandom);
            end
            for (int d = 0; d < 2; d++) begin
                last = int'(FS) + lat_of(d);
                if (abort_rel > 0 && abort_rel < last) last = abort_rel;
                checks++;
                if (busy[d] !== (rel <= last)) begin
                    errors++;
                    $display("FAIL busy dut%0d rel=%0d: got %0b expected %0b", d, rel, busy[d], rel <= last);
                end
                checks++;
                if ({proc_value[d], proc_threshold[d], proc_s[d]} !== {v0, th0, m0}) begin
                    errors++;
                    $display("FAIL cfg_hold dut%0d rel=%0d: got %h/%h/%b expected %h/%h/%b", d, rel,
                             proc_value[d], proc_threshold[d], proc_s[d], v0, th0, m0);
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Compares captured reads/writes/done against the frame model for both latencies.
    task automatic verify_frame(input string name, input int t0, input int abort_rel);
        int lat, nrd, nwr, ndone;
        for (int d = 0; d < 2; d++) begin
            lat   = lat_of(d);
            nrd   = (abort_rel > 0 && abort_rel < int'(FS)) ? abort_rel : int'(FS);
            nwr   = int'(FS);
            ndone = 1;
            if (abort_rel > 0) begin
                nwr   = abort_rel - lat;
                if (nwr < 0) nwr = 0;
                if (nwr > nrd) nwr = nrd;
                ndone = 0;
            end
            checks++;
            if (rq[d].size() != nrd) begin
                errors++;
                $display("FAIL %s_nreads dut%0d: got %0d expected %0d", name, d, rq[d].size(), nrd);
            end
            for (int i = 0; i < nrd && i < rq[d].size(); i++) begin
                checks++;
                if (rq[d][i].cyc != t0 + 1 + i || rq[d][i].addr != i) begin
                    errors++;
                    $display("FAIL %s_read[%0d] dut%0d: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d",
                             name, i, d, rq[d][i].cyc - t0, rq[d][i].addr, 1 + i, i);
                end
            end
            checks++;
            if (wq[d].size() != nwr) begin
                errors++;
                $display("FAIL %s_nwrites dut%0d: got %0d expected %0d", name, d, wq[d].size(), nwr);
            end
            for (int i = 0; i < nwr && i < wq[d].size(); i++) begin
                checks++;
                if (wq[d][i].cyc != t0 + 1 + i + lat || wq[d][i].addr != i || wq[d][i].data != int'(exp_data[i])) begin
                    errors++;
                    $display("FAIL %s_write[%0d] dut%0d: got cyc=%0d addr=%0d data=%0d expected cyc=%0d addr=%0d data=%0d",
                             name, i, d, wq[d][i].cyc - t0, wq[d][i].addr, wq[d][i].data,
                             1 + i + lat, i, exp_data[i]);
                end
            end
            checks++;
            if (dq[d].size() != ndone) begin
                errors++;
                $display("FAIL %s_ndone dut%0d: got %0d expected %0d", name, d, dq[d].size(), ndone);
            end
            if (ndone == 1 && dq[d].size() == 1) begin
                checks++;
                if (dq[d][0] != t0 + int'(FS) + lat + 1) begin
                    errors++;
                    $display("FAIL %s_done_cycle dut%0d: got %0d expected %0d", name, d,
                             dq[d][0] - t0, int'(FS) + lat + 1);
                end
            end
            checks++;
            if (int'(pix_cnt[d]) != nwr) begin
                errors++;
                $display("FAIL %s_pix_cnt dut%0d: got %0d expected %0d", name, d, pix_cnt[d], nwr);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (outs_of(d) !== 50'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h expected 0", d, outs_of(d));
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (outs_of(d) !== 50'd0) begin
                errors++;
                $display("FAIL idle_after_reset dut%0d: got %h expected 0", d, outs_of(d));
            end
        end
    endtask

    task automatic test_basic();
        int t0;
        for (int i = 0; i < int'(FS); i++) mem[i] = 8'(i);
        cfg_value = 8'($urandom); cfg_threshold = 8'($urandom); cfg_mode = 2'b11;
        drive_frame(0, 0, 1'b0, t0);
        verify_frame("basic", t0, 0);
    endtask

    task automatic test_cfg_latch();
        int t0;
        randomize_mem();
        cfg_value = 8'd60; cfg_threshold = 8'd160; cfg_mode = 2'b01;
        drive_frame(0, 0, 1'b1, t0);
        verify_frame("cfg_latch", t0, 0);
    endtask

    task automatic test_start_ignored();
        int t0;
        randomize_mem();
        cfg_value = 8'($urandom); cfg_threshold = 8'($urandom); cfg_mode = 2'b00;
        drive_frame(0, 3, 1'b0, t0);
        verify_frame("restart_run", t0, 0);
        randomize_mem();
        cfg_mode = 2'b10;
        drive_frame(0, 11, 1'b0, t0);
        verify_frame("restart_done", t0, 0);
    endtask

    task automatic test_abort();
        int t0;
        randomize_mem();
        cfg_value = 8'($urandom); cfg_threshold = 8'($urandom); cfg_mode = 2'($urandom);
        drive_frame(5, 0, 1'b0, t0);
        verify_frame("abort_run", t0, 5);
        randomize_mem();
        drive_frame(9, 0, 1'b0, t0);
        verify_frame("abort_drain", t0, 9);
    endtask

    task automatic test_abort_start_idle();
        @(posedge clk); #1;
        clear_queues();
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (busy[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_start_busy dut%0d k=%0d: got %0b expected 0", d, k, busy[d]);
                end
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rq[d].size() != 0 || wq[d].size() != 0) begin
                errors++;
                $display("FAIL abort_start_activity dut%0d: got reads=%0d writes=%0d expected 0/0",
                         d, rq[d].size(), wq[d].size());
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int t0;
        randomize_mem();
        cfg_value = 8'($urandom); cfg_threshold = 8'($urandom); cfg_mode = 2'($urandom);
        @(posedge clk); #1;
        clear_queues();
        start = 1'b1;
        for (int rel = 1; rel <= 9; rel++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (outs_of(d) !== 50'd0) begin
                errors++;
                $display("FAIL async_reset_outputs dut%0d: got %h expected 0", d, outs_of(d));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        randomize_mem();
        cfg_value = 8'($urandom); cfg_threshold = 8'($urandom); cfg_mode = 2'($urandom);
        drive_frame(0, 0, 1'b0, t0);
        verify_frame("after_reset", t0, 0);
    endtask

    task automatic test_random();
        int t0, ab, rs;
        for (int k = 0; k < 8; k++) begin
            randomize_mem();
            cfg_value = 8'($urandom); cfg_threshold = 8'($urandom); cfg_mode = 2'($urandom);
            ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(9, 2)) : 0;
            rs = int'($urandom_range(11, 2));
            if (ab != 0 && rs >= ab) rs = 0;
            drive_frame(ab, rs, 1'($urandom), t0);
            verify_frame("random", t0, ab);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_cfg_latch();
        test_start_ignored();
        test_abort();
        test_abort_start_idle();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_frame_sequencer.md
IMG_FRAME_SEQUENCER -- requirements
Module: img_frame_sequencer

Interface
REQ-001 Parameters (name, default, meaning): FRAME_SIZE, 98304, pixels per frame; ADDR_W, 17, pixel address width; SRC_LAT, 1, source-memory read latency in cycles; PROC_LAT, 0, img_processor latency in cycles (0 = combinational).
REQ-002 Ports (name direction width meaning): clk in 1 rising-edge clock; rst in 1 reset, asynchronous, active-high.
REQ-003 start in 1: one-cycle frame request; cfg_value in 8: brightness offset; cfg_threshold in 8: threshold; cfg_mode in 2: operation select; abort in 1: cancel frame.
REQ-004 src_rd_en out 1, src_addr out ADDR_W, src_data in 8: source-pixel memory read port.
REQ-005 proc_ip out 8, proc_value out 8, proc_threshold out 8, proc_s out 2, proc_op in 8: img_processor connection.
REQ-006 dst_wr_en out 1, dst_addr out ADDR_W, dst_data out 8: result-memory write port.
REQ-007 busy out 1, done out 1 (one-cycle pulse), pix_cnt out ADDR_W (writes completed in the current frame).

Function
REQ-008 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-009 In IDLE, start=1 SHALL latch cfg_value/threshold/mode into proc_value/proc_threshold/proc_s, clear the read and write counters and pix_cnt, and enter RUN on the next cycle.
REQ-010 Latched configuration SHALL remain constant until the next accepted start; cfg_* changes mid-frame SHALL have no effect.
REQ-011 In RUN, each cycle SHALL assert src_rd_en with src_addr = read counter, then increment; after address FRAME_SIZE-1 is issued, the FSM SHALL enter DRAIN.
REQ-012 Data returned SRC_LAT cycles after a read SHALL be registered into proc_ip on that edge; proc_op SHALL be sampled PROC_LAT cycles after proc_ip updates.
REQ-013 Per-pixel latency from src_rd_en to dst_wr_en SHALL be L = SRC_LAT + PROC_LAT + 1 cycles, tracked by an L-deep valid/address shift register.
REQ-014 dst_addr SHALL equal the source address of the same pixel; dst_data = proc_op; pix_cnt SHALL increment on each dst_wr_en.
REQ-015 DRAIN SHALL persist until the write for address FRAME_SIZE-1 is issued, then enter DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-016 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-017 start while busy or in DONE SHALL be ignored.
REQ-018 abort=1 in RUN or DRAIN SHALL enter IDLE on the next edge, flush the valid pipeline (no further dst_wr_en), and produce no done; abort and start in the same IDLE cycle: abort wins (no frame).
REQ-019 Counters SHALL not wrap; the read counter SHALL stop at FRAME_SIZE-1.
REQ-020 proc_ip SHALL hold its last value when no valid data arrives.

Reset
REQ-021 rst SHALL asynchronously force IDLE and set all outputs to 0: busy, done, src_rd_en, dst_wr_en, src_addr, dst_addr, dst_data, proc_ip, proc_value, proc_threshold, proc_s, pix_cnt; the valid pipeline SHALL be cleared.
REQ-022 rst mid-frame SHALL discard the frame; the first start after rst deasserts SHALL begin a new frame at address 0.

Structure
REQ-023 Shared package img_pkg SHALL hold the FSM state encoding, the FRAME_SIZE/ADDR_W defaults, and the mode constants (MODE_BRIGHT=2'b00, MODE_THRESH=2'b01, MODE_INVERT=2'b10, MODE_PASS=2'b11).
REQ-024 The latency-matching valid/address shift register SHALL be a sub-module, img_lat_pipe (parameterised depth and width).

Verification
REQ-025 FRAME_SIZE=8, SRC_LAT=1, PROC_LAT=0; source data 0..7; passthrough stub processor; start at cycle 0 -> writes at addresses 0..7 with data 0..7 on cycles 3..10, done pulse on cycle 11, pix_cnt=8.
REQ-026 cfg_value=60, cfg_threshold=160, cfg_mode=2'b01 at start, changed to 0 at cycle 4 -> proc_value=60, proc_threshold=160, proc_s=01 for the whole frame.
REQ-027 start re-pulsed at cycle 3 of a running frame -> ignored; exactly 8 writes and one done.
REQ-028 abort at cycle 5 -> busy=0 at cycle 6, no dst_wr_en after cycle 6, no done.
REQ-029 rst asserted asynchronously mid-DRAIN -> all outputs 0 immediately; new start yields a clean 8-pixel frame from address 0.
REQ-030 SRC_LAT=2, PROC_LAT=2 -> L=5; the first write occurs 5 cycles after the first read, and data/address pairing stays correct for all 8 pixels.
